shift_unit_seq: RTL and testbench

//   Parametrised multi-cycle shift unit for the CPU execute stage; generalises the single-mode SRA to SLL/SRL/SRA/ROR.

---
 rtl/shift_unit_seq.sv | 164 ++++++++++++++++
 tb/tb_shift_unit_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle SLL/SRL/SRA/ROR shift unit for the execute stage.
// Shifts up to STEP bits per cycle under a start/done handshake.
// Optional feature macro: SHIFT_FLAGS_EN adds cout (last bit shifted out) and zf (result zero).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; dalja/flags hold the last result
// S_SHIFT | shifting acc by min(STEP, rem) each cycle
// S_DONE  | one-cycle done pulse, dalja valid; back to S_IDLE next
module shift_unit_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] hyrja,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dalja
`ifdef SHIFT_FLAGS_EN
    ,
    output logic             cout,
    output logic             zf
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0]       MODE_SLL = 2'd0;
    localparam logic [1:0]       MODE_SRL = 2'd1;
    localparam logic [1:0]       MODE_SRA = 2'd2;
    localparam logic [SHW:0]     WIDTH_W  = (SHW+1)'(WIDTH);
    localparam logic [SHW:0]     STEP_W   = (SHW+1)'(STEP);
    localparam logic [WIDTH-1:0] ONES     = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] dalja_q, dalja_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SHW-1:0]   s;
    logic [SHW:0]     s_w;
    logic [WIDTH-1:0] shifted;

    // Step amount and one step of the selected shift applied to acc.
    always_comb begin
        s       = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[SHW-1:0];
        s_w     = {1'b0, s};
        shifted = acc_q;
        case (mode_q)
            MODE_SLL: shifted = acc_q << s;
            MODE_SRL: shifted = acc_q >> s;
            MODE_SRA: shifted = acc_q[WIDTH-1] ? ((acc_q >> s) | ~(ONES >> s)) : (acc_q >> s);
            default:  shifted = (acc_q >> s) | (acc_q << (WIDTH_W - s_w));
        endcase
    end

`ifdef SHIFT_FLAGS_EN
    logic             cout_q, cout_d;
    logic             zf_q, zf_d;
    logic             cout_step;
    logic [SHW-1:0]   idx_sll;
    logic [SHW-1:0]   idx_r;

    // Bit leaving acc on this step; for ROR this is also the new MSB.
    always_comb begin
        idx_sll   = SHW'(WIDTH_W - s_w);
        idx_r     = s - SHW'(1);
        cout_step = (mode_q == MODE_SLL) ? acc_q[idx_sll] : acc_q[idx_r];
    end
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        dalja_d = dalja_q;
`ifdef SHIFT_FLAGS_EN
        cout_d  = cout_q;
        zf_d    = zf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d  = hyrja;
                    rem_d  = shamt;
                    mode_d = mode;
                    if (shamt == '0) begin
                        state_d = S_DONE;
                        dalja_d = hyrja;
`ifdef SHIFT_FLAGS_EN
                        cout_d  = 1'b0;
                        zf_d    = (hyrja == '0);
`endif
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = shifted;
                rem_d = rem_q - s;
                if (rem_q == s) begin
                    state_d = S_DONE;
                    dalja_d = shifted;
`ifdef SHIFT_FLAGS_EN
                    cout_d  = cout_step;
                    zf_d    = (shifted == '0);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            dalja_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_FLAGS_EN
            cout_q  <= 1'b0;
            zf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            dalja_q <= dalja_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFT_FLAGS_EN
            cout_q  <= cout_d;
            zf_q    <= zf_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign dalja = dalja_q;
`ifdef SHIFT_FLAGS_EN
    assign cout  = cout_q;
    assign zf    = zf_q;
`endif

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: one STEP=1 and one STEP=4 instance share stimulus and
// are compared against an arithmetic reference of the four shift modes.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] hyrja;
    logic [3:0]  shamt;
    logic        busy1, done1, busy4, done4;
    logic [15:0] dalja1, dalja4;
`ifdef SHIFT_FLAGS_EN
    logic        cout1, zf1, cout4, zf4;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(16), .SHW(4), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hyrja(hyrja), .shamt(shamt),
        .busy(busy1), .done(done1), .dalja(dalja1)
`ifdef SHIFT_FLAGS_EN
        , .cout(cout1), .zf(zf1)
`endif
    );

    shift_unit_seq #(.WIDTH(16), .SHW(4), .STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hyrja(hyrja), .shamt(shamt),
        .busy(busy4), .done(done4), .dalja(dalja4)
`ifdef SHIFT_FLAGS_EN
        , .cout(cout4), .zf(zf4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_res(input logic [1:0] m, input logic [15:0] x, input int sh);
        case (m)
            2'd0:    return 16'(x << sh);
            2'd1:    return 16'(x >> sh);
            2'd2:    return 16'($signed(x) >>> sh);
            default: return 16'((x >> sh) | (x << (16 - sh)));
        endcase
    endfunction

    function automatic logic ref_cout(input logic [1:0] m, input logic [15:0] x, input int sh);
        logic [15:0] r;
        r = ref_res(m, x, sh);
        if (sh == 0)    return 1'b0;
        if (m == 2'd0)  return x[16 - sh];
        if (m == 2'd3)  return r[15];
        return x[sh - 1];
    endfunction

    // One operation on both instances; dbl keeps start high into the first busy cycle.
    task automatic run_op(input logic [1:0] m, input logic [15:0] x, input int sh, input bit dbl);
        logic [15:0] exp_r;
        logic [15:0] d1, d4;
        int lat1, lat4, last, c1, c4, l1, l4;
`ifdef SHIFT_FLAGS_EN
        logic co1, co4, z1, z4;
        co1 = 1'b0; co4 = 1'b0; z1 = 1'b0; z4 = 1'b0;
`endif
        exp_r = ref_res(m, x, sh);
        lat1  = sh + 1;
        lat4  = (sh + 3) / 4 + 1;
        last  = lat1 + 2;
        c1 = 0; c4 = 0; l1 = 0; l4 = 0; d1 = '0; d4 = '0;
        @(negedge clk);
        start = 1'b1; mode = m; hyrja = x; shamt = 4'(sh);
        chk("busy_idle", 32'(busy1 | busy4), 32'(0));
        for (int n = 1; n <= last; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start = dbl;
                mode  = 2'($urandom);
                hyrja = 16'($urandom);
                shamt = 4'($urandom);
                chk("busy_rise1", 32'(busy1), 32'(1));
                chk("busy_rise4", 32'(busy4), 32'(1));
            end else begin
                start = 1'b0;
            end
            if (done1) begin
                c1++;
                if (l1 == 0) begin
                    l1 = n; d1 = dalja1;
`ifdef SHIFT_FLAGS_EN
                    co1 = cout1; z1 = zf1;
`endif
                end
            end
            if (done4) begin
                c4++;
                if (l4 == 0) begin
                    l4 = n; d4 = dalja4;
`ifdef SHIFT_FLAGS_EN
                    co4 = cout4; z4 = zf4;
`endif
                end
            end
        end
        chk("latency1", 32'(l1), 32'(lat1));
        chk("latency4", 32'(l4), 32'(lat4));
        chk("done_cnt1", 32'(c1), 32'(1));
        chk("done_cnt4", 32'(c4), 32'(1));
        chk("dalja1", 32'(d1), 32'(exp_r));
        chk("dalja4", 32'(d4), 32'(exp_r));
        chk("dalja_hold1", 32'(dalja1), 32'(exp_r));
        chk("dalja_hold4", 32'(dalja4), 32'(exp_r));
        chk("busy_end", 32'(busy1 | busy4), 32'(0));
`ifdef SHIFT_FLAGS_EN
        chk("cout1", 32'(co1), 32'(ref_cout(m, x, sh)));
        chk("cout4", 32'(co4), 32'(ref_cout(m, x, sh)));
        chk("zf1", 32'(z1), 32'(exp_r == 16'h0));
        chk("zf4", 32'(z4), 32'(exp_r == 16'h0));
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = '0; hyrja = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy1 | busy4), 32'(0));
        chk("rst_done", 32'(done1 | done4), 32'(0));
        chk("rst_dalja1", 32'(dalja1), 32'(0));
        chk("rst_dalja4", 32'(dalja4), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, including shamt extremes and a start held while busy.
        run_op(2'd2, 16'h8000, 4, 1'b0);
        run_op(2'd1, 16'h8000, 4, 1'b0);
        run_op(2'd0, 16'h0001, 15, 1'b0);
        run_op(2'd3, 16'h0001, 1, 1'b0);
        run_op(2'd2, 16'h1234, 0, 1'b1);
        run_op(2'd2, 16'h8000, 7, 1'b1);
        run_op(2'd1, 16'h0003, 1, 1'b0);
        run_op(2'd0, 16'h8000, 1, 1'b0);
        run_op(2'd3, 16'hA5C3, 15, 1'b0);
        run_op(2'd2, 16'hFFFF, 15, 1'b0);

        // Reset during the second SHIFT cycle of a shamt=8 operation.
        @(negedge clk);
        start = 1'b1; mode = 2'd1; hyrja = 16'hABCD; shamt = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy1 | busy4), 32'(0));
        chk("abort_done", 32'(done1 | done4), 32'(0));
        chk("abort_dalja1", 32'(dalja1), 32'(0));
        chk("abort_dalja4", 32'(dalja4), 32'(0));
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done1 | done4), 32'(0));
        end
        run_op(2'd1, 16'hABCD, 8, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), 16'($urandom), int'($urandom_range(15, 0)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
